// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit stream stage.
//   - uart_state_e : FSM state encoding (IDLE, LOAD, START, DATA, STOP, DONE)
//   - DATA_BITS    : payload bits per frame (8N1 framing)
//   - LINE_IDLE    : serial line level when no frame is in flight
//   - clog2()      : ceiling log2 with a minimum result of 1, used to size
//                    counters so a degenerate DIV still yields a 1-bit vector
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4,
    DONE  = 3'd5
  } uart_state_e;

  localparam int   DATA_BITS = 8;
  localparam logic LINE_IDLE = 1'b1;

  // Smallest width able to hold values 0..value-1, never less than 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        result = i + 1;
      end
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// -----------------------------------------------------------------------------
// uart_baud_cnt
// Free-running bit-period counter. Counts 0..DIV-1 and wraps; clr holds it
// at zero so the first bit period after clr drops is a full DIV clocks.
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   clr     in  hold counter at zero (synchronous)
//   bit_end out high while the count equals DIV-1 (last clock of a bit)
// -----------------------------------------------------------------------------
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end
);

  localparam int             CNT_W = clog2(DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;

  // Bit-period counter: cleared on request, wraps at DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (cnt_r == LAST) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
    end
  end

  assign bit_end = (cnt_r == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// -----------------------------------------------------------------------------
// uart_tx_stream
// 8N1 UART transmitter fed from a synchronous-read frame RAM. When enabled in
// IDLE it waits MEM_LAT clocks for the RAM output to settle on the current
// address, latches the byte, sends start/data/stop bits of DIV clocks each,
// and pulses tx_tick for one clock so the address sequencer can advance.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   en       in  transmit enable (level, only looked at in IDLE)
//   rd_data  in  frame-RAM read data for the current address
//   tx       out serial line, idle high
//   tx_tick  out one-clock pulse after the last stop bit
//   busy     out high in every state except IDLE
// -----------------------------------------------------------------------------
module uart_tx_stream
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DIV       = CLK_FREQ / BAUD,
  parameter int MEM_LAT   = 1,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] rd_data,
  output logic       tx,
  output logic       tx_tick,
  output logic       busy
);

  localparam logic [1:0] WAIT_INIT = 2'(MEM_LAT);
  localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  uart_state_e state_r;
  logic [1:0]  wait_r;
  logic [2:0]  bit_idx_r;
  logic [7:0]  shift_r;
  logic        tx_r;
  logic        tick_r;
  logic        busy_r;
  logic        clr_s;
  logic        bit_end_s;

  // Baud counter only runs in the bit-timed states; holding it at zero
  // elsewhere guarantees each frame is aligned to its own START entry.
  always_comb begin
    clr_s = 1'b1;
    case (state_r)
      START, DATA, STOP: clr_s = 1'b0;
      default:           clr_s = 1'b1;
    endcase
  end

  uart_baud_cnt #(
    .DIV(DIV)
  ) u_baud_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr_s),
    .bit_end(bit_end_s)
  );

  // Frame FSM; tx/tx_tick/busy are registered with their next-state values
  // so they line up exactly with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      wait_r    <= 2'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      tx_r      <= LINE_IDLE;
      tick_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      case (state_r)
        IDLE: begin
          tx_r <= LINE_IDLE;
          if (en) begin
            busy_r <= 1'b1;
            if (MEM_LAT == 0) begin
              // RAM data is already valid: latch now, start bit next.
              shift_r <= rd_data;
              tx_r    <= 1'b0;
              state_r <= START;
            end else begin
              wait_r  <= WAIT_INIT;
              state_r <= LOAD;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end

        LOAD: begin
          // Latch on the edge where the wait count reaches zero.
          if (wait_r <= 2'd1) begin
            wait_r  <= 2'd0;
            shift_r <= rd_data;
            tx_r    <= 1'b0;
            state_r <= START;
          end else begin
            wait_r <= wait_r - 2'd1;
          end
        end

        START: begin
          if (bit_end_s) begin
            bit_idx_r <= 3'd0;
            tx_r      <= shift_r[0];
            state_r   <= DATA;
          end
        end

        DATA: begin
          if (bit_end_s) begin
            shift_r <= {1'b0, shift_r[7:1]};
            if (bit_idx_r == LAST_DATA) begin
              bit_idx_r <= 3'd0;
              tx_r      <= LINE_IDLE;
              state_r   <= STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              // Next LSB is bit 1 of the pre-shift value.
              tx_r      <= shift_r[1];
            end
          end
        end

        STOP: begin
          tx_r <= LINE_IDLE;
          if (bit_end_s) begin
            if (bit_idx_r == LAST_STOP) begin
              bit_idx_r <= 3'd0;
              tick_r    <= 1'b1;
              state_r   <= DONE;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end
        end

        DONE: begin
          tx_r    <= LINE_IDLE;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end

        default: begin
          tx_r      <= LINE_IDLE;
          busy_r    <= 1'b0;
          wait_r    <= 2'd0;
          bit_idx_r <= 3'd0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_r;
  assign tx_tick = tick_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_uart_tx_stream.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_stream
// Four instances share clk/rst_n/rd_data:
//   0: STOP_BITS=1 MEM_LAT=1   1: STOP_BITS=2 MEM_LAT=1
//   2: STOP_BITS=1 MEM_LAT=0   3: STOP_BITS=1 MEM_LAT=3
// Expected line waveform is derived from the frame as a bit list: LOAD wait,
// then start/data(LSB first)/stop slots of DIV clocks each, one DONE clock.
// -----------------------------------------------------------------------------
module tb_uart_tx_stream;

  localparam int DIV = 16;

  logic       clk;
  logic       rst_n;
  logic [7:0] rd_data;
  logic [3:0] en_v;
  logic [3:0] tx_v;
  logic [3:0] tick_v;
  logic [3:0] busy_v;

  int n_checks;
  int n_fail;

  uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .MEM_LAT(1), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rd_data(rd_data),
    .tx(tx_v[0]), .tx_tick(tick_v[0]), .busy(busy_v[0]));
  uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .MEM_LAT(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rd_data(rd_data),
    .tx(tx_v[1]), .tx_tick(tick_v[1]), .busy(busy_v[1]));
  uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .MEM_LAT(0), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en_v[2]), .rd_data(rd_data),
    .tx(tx_v[2]), .tx_tick(tick_v[2]), .busy(busy_v[2]));
  uart_tx_stream #(.CLK_FREQ(16), .BAUD(1), .MEM_LAT(3), .STOP_BITS(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en_v[3]), .rd_data(rd_data),
    .tx(tx_v[3]), .tx_tick(tick_v[3]), .busy(busy_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one frame on instance idx. Caller has en high before the next
  // posedge, which is the edge that samples it (e=0). drop_at >= 0 lowers en
  // at that cycle; next_byte is presented on rd_data during the tick cycle.
  task automatic frame_check(input int idx, input logic [7:0] exp_byte,
                             input int lat, input int stops, input int drop_at,
                             input logic [7:0] next_byte);
    logic [11:0] bits;
    logic [7:0]  got;
    logic        exp_tx, exp_tick, exp_busy;
    int          frame_len, slot;
    bits = 12'hFFF;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = exp_byte[i];
    frame_len = (9 + stops) * DIV;
    got = 8'h00;
    @(posedge clk);
    for (int e = 0; e <= lat + frame_len + 1; e++) begin
      @(negedge clk);
      if (e == drop_at) en_v[idx] = 1'b0;
      if (e < lat) begin
        exp_tx = 1'b1; exp_tick = 1'b0; exp_busy = 1'b1;
      end else if (e < lat + frame_len) begin
        slot = (e - lat) / DIV;
        exp_tx = bits[slot]; exp_tick = 1'b0; exp_busy = 1'b1;
        if (((e - lat) % DIV) == DIV / 2 && slot >= 1 && slot <= 8)
          got[slot-1] = tx_v[idx];
      end else if (e == lat + frame_len) begin
        exp_tx = 1'b1; exp_tick = 1'b1; exp_busy = 1'b1;
      end else begin
        exp_tx = 1'b1; exp_tick = 1'b0; exp_busy = 1'b0;
      end
      n_checks++;
      if (tx_v[idx] !== exp_tx) begin
        n_fail++;
        $display("FAIL frame_tx inst=%0d byte=%h e=%0d got %b exp %b", idx, exp_byte, e, tx_v[idx], exp_tx);
      end
      n_checks++;
      if (tick_v[idx] !== exp_tick) begin
        n_fail++;
        $display("FAIL frame_tick inst=%0d byte=%h e=%0d got %b exp %b", idx, exp_byte, e, tick_v[idx], exp_tick);
      end
      n_checks++;
      if (busy_v[idx] !== exp_busy) begin
        n_fail++;
        $display("FAIL frame_busy inst=%0d byte=%h e=%0d got %b exp %b", idx, exp_byte, e, busy_v[idx], exp_busy);
      end
      // Scramble RAM data while the byte is in flight; present next byte at tick.
      if (e == lat + frame_len) rd_data = next_byte;
      else if (e >= lat && e < lat + frame_len) rd_data = 8'($urandom);
    end
    n_checks++;
    if (got !== exp_byte) begin
      n_fail++;
      $display("FAIL frame_decode inst=%0d got %h exp %h", idx, got, exp_byte);
    end
  endtask

  task automatic idle_check(input int idx, input int cycles, input string name);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      n_checks++;
      if (tx_v[idx] !== 1'b1 || tick_v[idx] !== 1'b0 || busy_v[idx] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s inst=%0d c=%0d got tx/tick/busy %b%b%b exp 100", name, idx, c,
                 tx_v[idx], tick_v[idx], busy_v[idx]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (tx_v[i] !== 1'b1 || tick_v[i] !== 1'b0 || busy_v[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_values inst=%0d got tx/tick/busy %b%b%b exp 100", i, tx_v[i], tick_v[i], busy_v[i]);
        end
      end
    end
    rst_n = 1'b1;
    idle_check(0, 50, "post_reset_idle");
  endtask

  task automatic test_single_byte;
    @(negedge clk);
    rd_data = 8'hA5;
    en_v[0] = 1'b1;
    frame_check(0, 8'hA5, 1, 1, -1, 8'hA5);
    en_v[0] = 1'b0;
    idle_check(0, 5, "single_after");
  endtask

  task automatic test_streaming;
    logic [7:0] seq [0:5];
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
    for (int i = 3; i < 6; i++) seq[i] = 8'($urandom);
    @(negedge clk);
    rd_data = seq[0];
    en_v[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame_check(0, seq[i], 1, 1, -1, (i < 5) ? seq[i+1] : seq[i]);
    end
    en_v[0] = 1'b0;
    idle_check(0, 5, "stream_after");
  endtask

  task automatic test_en_drop;
    @(negedge clk);
    rd_data = 8'h55;
    en_v[0] = 1'b1;
    frame_check(0, 8'h55, 1, 1, 40, 8'h55);
    idle_check(0, 30, "en_drop_idle");
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b0, b1;
    b0 = 8'($urandom) & 8'hF7;
    b1 = 8'($urandom);
    @(negedge clk);
    rd_data = b0;
    en_v[0] = 1'b1;
    @(posedge clk);
    // 70 edges after the sampling edge lands mid data bit 3.
    repeat (70) @(posedge clk);
    #1;
    n_checks++;
    if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_bit3 got tx/busy %b%b exp 01", tx_v[0], busy_v[0]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_v[0] !== 1'b1 || tick_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got tx/tick/busy %b%b%b exp 100", tx_v[0], tick_v[0], busy_v[0]);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (tick_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_hold c=%0d got tx/tick %b%b exp 10", c, tx_v[0], tick_v[0]);
      end
    end
    rd_data = b1;
    rst_n = 1'b1;
    frame_check(0, b1, 1, 1, -1, b1);
    en_v[0] = 1'b0;
    idle_check(0, 5, "reset_mid_after");
  endtask

  task automatic test_param_sweep;
    @(negedge clk);
    rd_data = 8'h81;
    en_v[1] = 1'b1;
    frame_check(1, 8'h81, 1, 2, -1, 8'h81);
    en_v[1] = 1'b0;
    idle_check(1, 3, "stop2_after");
    @(negedge clk);
    rd_data = 8'h81;
    en_v[2] = 1'b1;
    frame_check(2, 8'h81, 0, 1, -1, 8'h81);
    en_v[2] = 1'b0;
    idle_check(2, 3, "lat0_after");
    @(negedge clk);
    rd_data = 8'h81;
    en_v[3] = 1'b1;
    frame_check(3, 8'h81, 3, 1, -1, 8'h81);
    en_v[3] = 1'b0;
    idle_check(3, 3, "lat3_after");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    en_v = 4'b0000;
    rd_data = 8'h00;
    test_reset();
    test_single_byte();
    test_streaming();
    test_en_drop();
    test_reset_mid_frame();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
